// File: rtl/offchip_data_memory.sv
// Slow off-chip block memory behind the data cache: 256-bit block reads/writes
// with a fixed request-to-ack latency and a one-cycle completion pulse.
module offchip_data_memory #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY);
  localparam int unsigned OFF_W = 5;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [255:0]       memory [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic               last_c;
  logic               unused_addr;

  // Byte offset within the block and bits above the array size are don't-care.
  assign idx         = addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^{addr_i[31:OFF_W+IDX_W], addr_i[OFF_W-1:0]};

  // Final cycle of a live request; a dropped enable suppresses ack and write.
  assign last_c = (state == WAIT) && enable_i && (count == CNT_W'(LATENCY - 1));

  assign ack_o  = last_c;
  assign data_o = last_c ? memory[idx] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (enable_i) state <= WAIT;
        end
        WAIT: begin
          if (!enable_i || last_c) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Storage is intentionally not reset; the write lands at the edge closing the ack cycle.
  always_ff @(posedge clk_i) begin
    if (last_c && write_i) memory[idx] <= data_i;
  end

endmodule

// File: tb/tb_offchip_data_memory.sv
// Bench for offchip_data_memory: transaction-level model with a per-cycle
// compare of ack_o/data_o plus directed literal checks.
module tb_offchip_data_memory;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         enable = 1'b0;
  logic         write = 1'b0;
  logic         ack;
  logic [255:0] rdata;

  offchip_data_memory #(.DEPTH(512), .LATENCY(LAT)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [255:0] d;
  } exp_t;

  exp_t         q[$];
  logic [255:0] model_mem [512];
  int           cyc = 0;
  int           cmp_n = 0;
  int           err_n = 0;
  int           k_acc = 0;
  int           cur_idx = 0;
  logic         cur_wr = 1'b0;
  logic [255:0] cur_wd = '0;

  localparam logic [255:0] M0  = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] M1  = 256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [255:0] M2  = {16{16'hECFA}};
  localparam logic [255:0] M3  = {8{32'h3333_CAFE}};
  localparam logic [255:0] M16 = {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
  localparam logic [255:0] M32 = 256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;
  localparam logic [255:0] W55 = {16{16'h5555}};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endfunction

  // Per-cycle check: ack/data must match the scheduled completion, else both low/zero.
  always @(negedge clk) begin
    logic         ea;
    logic [255:0] ed;
    ea = 1'b0;
    ed = '0;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("stale_ack_slot", 256'(q[0].cyc), 256'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ea = 1'b1;
      ed = q[0].d;
      void'(q.pop_front());
    end
    chk("cyc_ack", 256'(ack), 256'(ea));
    chk("cyc_data", rdata, ed);
  end

  task automatic preload(input int i, input logic [255:0] v);
    dut.memory[i] = v;
    model_mem[i] = v;
  endtask

  task automatic start_req(input logic [31:0] a, input logic wr, input logic [255:0] wd);
    exp_t e;
    @(posedge clk); #2;
    addr = a; write = wr; wdata = wd; enable = 1'b1;
    cur_idx = int'(a[13:5]); cur_wr = wr; cur_wd = wd;
    k_acc = cyc + 1;
    e.cyc = k_acc + LAT - 1;
    e.d = model_mem[cur_idx];
    q.push_back(e);
  endtask

  task automatic wait_ack(input string nm, input logic [255:0] exp_lit);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * LAT && !seen; n++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 256'(0), 256'(1));
    end else begin
      chk({nm, "_data"}, rdata, exp_lit);
      chk({nm, "_lat"}, 256'(cyc - k_acc), 256'(LAT - 1));
    end
  endtask

  task automatic finish_req(input string nm);
    @(posedge clk); #2;
    enable = 1'b0;
    if (cur_wr) model_mem[cur_idx] = cur_wd;
    chk({nm, "_mem"}, dut.memory[cur_idx], model_mem[cur_idx]);
  endtask

  task automatic txn(input string nm, input logic [31:0] a, input logic wr,
                     input logic [255:0] wd, input logic [255:0] exp_lit);
    start_req(a, wr, wd);
    wait_ack(nm, exp_lit);
    finish_req(nm);
  endtask

  initial begin
    int a1;
    exp_t e;
    preload(0, M0);
    preload(1, M1);
    preload(2, M2);
    preload(3, M3);
    preload(16, M16);
    preload(32, M32);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ack", 256'(ack), 256'(0));
    chk("reset_data", rdata, '0);
    rst_n = 1'b1;

    txn("t1_read", 32'h0000_0020, 1'b0, '0, M1);

    txn("t2_write", 32'h0000_0040, 1'b1, W55, M2);
    chk("t2_mem2_lit", dut.memory[2], W55);
    txn("t2_read", 32'h0000_0040, 1'b0, '0, W55);

    txn("t3_alias_4000", 32'h0000_4000, 1'b0, '0, M0);
    txn("t3_alias_021f", 32'h0000_021F, 1'b0, '0, M16);

    // Reset while count = 5 during a write.
    start_req(32'h0000_0400, 1'b1, {8{32'hDEAD_BEEF}});
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0; enable = 1'b0; q.delete();
    #1;
    chk("t4_ack_in_rst", 256'(ack), 256'(0));
    repeat (2) @(posedge clk);
    #2;
    chk("t4_mem32_kept", dut.memory[32], M32);
    rst_n = 1'b1;
    txn("t4_read_after", 32'h0000_0400, 1'b0, '0, M32);

    // Reset landing inside an ack cycle drops ack and data at once.
    start_req(32'h0000_0020, 1'b0, '0);
    repeat (LAT) @(posedge clk);
    #2;
    chk("t4b_ack_before", 256'(ack), 256'(1));
    chk("t4b_data_before", rdata, M1);
    rst_n = 1'b0; enable = 1'b0; q.delete();
    #1;
    chk("t4b_ack_after", 256'(ack), 256'(0));
    chk("t4b_data_after", rdata, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Enable held high across two reads: second acceptance one edge after the first ack edge.
    start_req(32'h0000_0020, 1'b0, '0);
    e.cyc = k_acc + 2 * LAT;
    e.d = model_mem[1];
    q.push_back(e);
    wait_ack("t5_b2b_first", M1);
    a1 = cyc;
    k_acc = k_acc + LAT + 1;
    wait_ack("t5_b2b_second", M1);
    chk("t5_ack_spacing", 256'(cyc - a1), 256'(11));
    finish_req("t5_b2b");

    // Enable dropped at count = 3: no ack, no write.
    start_req(32'h0000_0060, 1'b1, {8{32'h0BAD_F00D}});
    repeat (4) @(posedge clk);
    #2;
    enable = 1'b0;
    void'(q.pop_back());
    repeat (3 * LAT) @(posedge clk);
    #2;
    chk("t5_abort_mem3", dut.memory[3], M3);
    txn("t5_abort_read", 32'h0000_0060, 1'b0, '0, M3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/offchip_data_memory.md
Name: offchip_data_memory

Overview:
- Models the slow off-chip data memory behind the CPU's 2-way data cache.
- Holds 512 blocks of 256 bits (16 KB) and serves whole-block reads and writes.
- Each access takes a fixed multi-cycle latency and completes with a one-cycle ack pulse.
- The cache controller is its only master. The testbench preloads and inspects the storage array hierarchically.

Parameters:
- DEPTH, 512, number of 256-bit blocks.
- LATENCY, 10, cycles from request acceptance to the ack cycle, inclusive (minimum 2).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- addr_i  input  32  byte address of the block.
- data_i  input  256  write data for the whole block.
- enable_i  input  1  request valid; held high until ack.
- write_i  input  1  1 = write request, 0 = read request.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read data, valid only while ack_o = 1.

Behaviour:
- Storage:
  - Array named memory, DEPTH entries x 256 bits, hierarchically accessible as memory[i].
  - Contents are not cleared by reset.
- Addressing:
  - Block index = addr_i[13:5]. addr_i[4:0] is ignored.
  - addr_i[31:14] is ignored, so addresses alias modulo 16 KB.
- Reset (rst_i low, asynchronous):
  - state = IDLE, count = 0, ack_o = 0, data_o = 0.
  - Any in-flight request is aborted and no write occurs.
- State machine:
  - IDLE:
    - At a rising edge with enable_i = 1, go to WAIT with count = 0.
    - Otherwise stay in IDLE.
  - WAIT:
    - count increments at each rising edge.
    - ack_o = 1 combinationally while count == LATENCY-1.
    - At the edge ending the ack cycle, return to IDLE and clear count.
  - enable_i low in WAIT: abort, return to IDLE at the next edge, no ack and no write.
- Latency:
  - Request accepted at edge k.
  - ack_o is high during the cycle between edge k+LATENCY-1 and edge k+LATENCY.
- Read:
  - data_o = memory[index] during the ack cycle, combinational from the current addr_i.
  - data_o = 0 at all other times.
- Write:
  - memory[index] <= data_i at the rising edge that ends the ack cycle (ack_o = 1 and write_i = 1).
  - data_o still shows the pre-write contents during the ack cycle.
- Master contract:
  - addr_i, data_i and write_i must be held stable from acceptance through the ack cycle.
  - Changes during WAIT are not tracked; the values present during the ack cycle are used.
- Back-to-back requests:
  - After the ack edge the block is in IDLE.
  - A request still or newly asserted there is accepted at the following edge, giving at least one idle cycle between acks.
- Single outstanding request; no pipelining and no queueing.
- enable_i high while write_i toggles mid-WAIT: the write_i value sampled in the ack cycle decides read vs write.

Test Plan:
1. Preload memory[1] = 8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000.
   - Read addr_i = 0x0000_0020 accepted at edge 0.
   - ack_o is high only in the cycle after edge 9, with data_o equal to the preloaded value.
   - data_o = 0 in every other cycle.
2. Write 256'h5555…5555 to addr_i = 0x0000_0040 (memory[2] preloaded ECFA…ECFA).
   - During the ack cycle data_o shows ECFA…ECFA.
   - After the ack edge memory[2] = 5555…5555.
   - A following read of 0x40 returns 5555…5555 after 10 cycles.
3. Aliasing:
   - Read addr_i = 0x0000_4000 returns memory[0] = 0000_1111_…_EEEE_FFFF.
   - Read addr_i = 0x0000_021F returns memory[16] = 0123_4567_…_7654_3210.
4. Reset mid-operation:
   - Start a write to 0x0400, then pull rst_i low at count = 5.
   - ack_o drops immediately, state returns to IDLE, memory[32] still = 0000_1001_…_F00F.
   - After rst_i rises, a new read completes normally in 10 cycles.
5. Back-to-back with enable_i held high across two requests:
   - Acks occur 11 cycles apart, each exactly one cycle wide.
   - enable_i deasserted at count = 3 yields no ack and memory is unchanged.
